alu_md_ctrl: RTL and testbench
==============================

# alu_md_ctrl

Decode-and-sequence control for the execute stage of the 5-stage pipeline. Successor to the purely combinational ALU control decode: it generates the same ALU op, shift amount and sign-extend select from the D/X instruction and adds a sequencer for multi-cycle multiply/divide. The sequencer issues to the mult/div unit, stalls the front end, enforces a timeout and produces the write-back request (result or exception status).

## Interface
- `TIMEOUT`, 64: max cycles from issue to `md_resultRdy` before a timeout exception; range 2..255.
- `MULT_EXC`, 4: status code written on mult exception/timeout.
- `DIV_EXC`, 5: status code written on div exception/timeout.
- `STATUS_REG`, 30: destination register for exception status.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `DXIR`  in  32  D/X latch instruction.
- `dx_valid`  in  1  D/X holds a real (non-bubble) instruction.
- `flush`  in  1  squash D/X this cycle (branch/jump taken).
- `md_resultRdy`  in  1  mult/div unit result valid (1-cycle pulse).
- `md_exception`  in  1  qualifies `md_resultRdy`; high means overflow/div-by-zero.
- `aluOp`  out  5  ALU operation.
- `sham`  out  5  shift amount.
- `SXmux`  out  1  1 selects sign-extended immediate as ALU B.
- `ctrlMult`, `ctrlDiv`  out  1  one-cycle start pulses to the mult/div unit.
- `stall`  out  1  freeze PC, F/D and D/X; insert bubble into X/M.
- `md_wb_valid`  out  1  one-cycle write-back request.
- `md_wb_rd`  out  5  write-back register.
- `md_wb_isExc`  out  1  write-back carries a status code, not the unit result.
- `md_wb_code`  out  32  zero-extended status code (0 when `md_wb_isExc`=0).

## Operation
- Fields: opcode=DXIR[31:27], func=DXIR[6:2], shamt=DXIR[11:7], rd=DXIR[26:22].
- Decode (combinational): isMD = opcode 0 and func in {6,7}. isBranch = opcode in {2,6,22}. aluOp = func when opcode 0 and not isMD; 1 when isBranch; else 0. sham = shamt when opcode 0, else 0. SXmux = opcode not in {0,2,6,22}.
- FSM states: IDLE, BUSY, DONE. Registered: state, 8-bit cycle counter, captured rd, captured kind (mult/div).
- IDLE: if dx_valid & isMD & !flush, issue: pulse ctrlMult (func 6) or ctrlDiv (func 7), capture rd and kind, clear counter, go BUSY.
- BUSY: counter increments each cycle. On md_resultRdy, go DONE with the exception flag latched from md_exception. If the counter reaches TIMEOUT-1 without md_resultRdy, go DONE with exception forced.
- DONE: md_wb_valid=1 for exactly one cycle. On no exception: md_wb_rd=captured rd, md_wb_isExc=0. On exception: md_wb_rd=STATUS_REG, md_wb_isExc=1, md_wb_code=MULT_EXC or DIV_EXC by kind. Then go IDLE.
- stall = issue-cycle condition in IDLE, or state BUSY. Stall is low in DONE, so the instruction leaves D/X that cycle.
- flush in BUSY: return to IDLE with no write-back. stall drops the same cycle (combinational on flush). A late md_resultRdy is ignored in IDLE.
- md_resultRdy in IDLE or DONE is ignored. No re-issue while BUSY, since DXIR is held.

## Timing
- Reset: state IDLE, counter 0, captured regs 0. ctrlMult, ctrlDiv, md_wb_valid, md_wb_isExc = 0; md_wb_rd = 0; md_wb_code = 0. stall follows the decode of DXIR.
- Issue cycle T: ctrl pulse and stall at T; BUSY from T+1.
- Result at cycle R (BUSY): DONE at R+1 with wb; IDLE at R+2. A back-to-back mult/div in D/X can issue at R+2.
- Minimum issue-to-writeback: 2 cycles. Timeout write-back occurs at T+TIMEOUT+1.
- Reset mid-BUSY returns to IDLE next edge with no write-back.

## Structure
- Shared package `proc_pkg`: opcode constants (ALU=0, BNE=2, BLT=6, BEX=22), func codes MUL=6 and DIV=7, field bit positions, FSM state encoding.
- Sub-module `alu_decode`: the combinational decode (aluOp, sham, SXmux, isMD, kind). The FSM and counter stay in the top module.

## Test plan
- add (opcode 0, func 0, shamt 3) → aluOp=0, sham=3, SXmux=0, no stall. addi (opcode 5) → aluOp=0, sham=0, SXmux=1. bne (opcode 2) → aluOp=1.
- mult rd=7, md_resultRdy 4 cycles after issue, no exception → ctrlMult 1 cycle, stall 5 cycles, wb rd=7, md_wb_isExc=0.
- div rd=3, md_resultRdy with md_exception=1 → wb rd=30, md_wb_code=5.
- mult with no md_resultRdy, TIMEOUT=8 → wb at T+9, rd=30, md_wb_code=4.
- flush 2 cycles into BUSY, then md_resultRdy → state IDLE, no md_wb_valid, stall low the flush cycle.
- Reset asserted mid-BUSY → all outputs at reset values. Back-to-back mult then div → second issue exactly 2 cycles after first result.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the execute-stage control slice.
// Holds the instruction opcode/func encodings, the bit positions of the
// D/X instruction fields, and the encodings used by the mult/div sequencer.
package proc_pkg;

  // Opcodes (DXIR[31:27])
  localparam logic [4:0] OPC_ALU = 5'd0;
  localparam logic [4:0] OPC_BNE = 5'd2;
  localparam logic [4:0] OPC_BLT = 5'd6;
  localparam logic [4:0] OPC_BEX = 5'd22;

  // ALU-format func codes (DXIR[6:2]) that go to the mult/div unit
  localparam logic [4:0] FUNC_MUL = 5'd6;
  localparam logic [4:0] FUNC_DIV = 5'd7;

  // Low bit of each 5-bit instruction field
  localparam int OPC_LSB   = 27;
  localparam int RD_LSB    = 22;
  localparam int SHAMT_LSB = 7;
  localparam int FUNC_LSB  = 2;

  // Mult/div sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  // Which unit an issued operation went to
  typedef enum logic {
    KIND_MUL = 1'b0,
    KIND_DIV = 1'b1
  } md_kind_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of the D/X instruction for the execute stage.
// Ports:
//   i_ir       in  32  D/X instruction
//   o_alu_op   out 5   ALU operation
//   o_sham     out 5   shift amount
//   o_sx_mux   out 1   select sign-extended immediate as ALU B
//   o_is_md    out 1   instruction is a multiply or divide
//   o_kind     out 1   mult or div (meaningful only when o_is_md)
module alu_decode
  import proc_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [4:0]  o_alu_op,
  output logic [4:0]  o_sham,
  output logic        o_sx_mux,
  output logic        o_is_md,
  output md_kind_t    o_kind
);

  logic [4:0] w_opc;
  logic [4:0] w_func;
  logic [4:0] w_shamt;
  logic       w_is_alu;
  logic       w_is_branch;
  logic       w_unused_ir;

  assign w_opc   = i_ir[OPC_LSB +: 5];
  assign w_func  = i_ir[FUNC_LSB +: 5];
  assign w_shamt = i_ir[SHAMT_LSB +: 5];

  // Register specifiers and the low two bits are not needed by the decode
  assign w_unused_ir = ^{i_ir[26:12], i_ir[1:0]};

  assign w_is_alu    = (w_opc == OPC_ALU);
  assign w_is_branch = (w_opc == OPC_BNE) || (w_opc == OPC_BLT) || (w_opc == OPC_BEX);
  assign o_is_md     = w_is_alu && ((w_func == FUNC_MUL) || (w_func == FUNC_DIV));
  assign o_kind      = (w_func == FUNC_DIV) ? KIND_DIV : KIND_MUL;

  always_comb begin
    o_alu_op = 5'd0;
    if (w_is_alu && !o_is_md) begin
      o_alu_op = w_func;
    end else if (w_is_branch) begin
      o_alu_op = 5'd1;
    end
  end

  assign o_sham   = w_is_alu ? w_shamt : 5'd0;
  // Immediate-format instructions are everything except ALU and branches
  assign o_sx_mux = !(w_is_alu || w_is_branch);

endmodule

// File: rtl/alu_md_ctrl.sv
// Execute-stage control: ALU decode plus a sequencer for multi-cycle
// multiply/divide. The sequencer issues a start pulse, stalls the front end
// while the unit works, enforces a timeout, and raises a one-cycle write-back
// request carrying either the unit result destination or an exception status.
// Ports:
//   clock, reset            clock; synchronous active-high reset
//   DXIR, dx_valid, flush   D/X instruction, non-bubble flag, squash request
//   md_resultRdy            mult/div result pulse, md_exception qualifies it
//   aluOp, sham, SXmux      ALU decode outputs
//   ctrlMult, ctrlDiv       start pulses to the mult/div unit
//   stall                   freeze PC, F/D, D/X; bubble into X/M
//   md_wb_*                 write-back request, register, exception flag, code
//   dbg_state               current sequencer state (md_state_t encoding)
module alu_md_ctrl
  import proc_pkg::*;
#(
  parameter int TIMEOUT    = 64,
  parameter int MULT_EXC   = 4,
  parameter int DIV_EXC    = 5,
  parameter int STATUS_REG = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] DXIR,
  input  logic        dx_valid,
  input  logic        flush,
  input  logic        md_resultRdy,
  input  logic        md_exception,
  output logic [4:0]  aluOp,
  output logic [4:0]  sham,
  output logic        SXmux,
  output logic        ctrlMult,
  output logic        ctrlDiv,
  output logic        stall,
  output logic        md_wb_valid,
  output logic [4:0]  md_wb_rd,
  output logic        md_wb_isExc,
  output logic [31:0] md_wb_code,
  output logic [1:0]  dbg_state
);

  // Counter value in the last BUSY cycle before a forced timeout; the
  // counter is 0 in the first BUSY cycle, so write-back lands at T+TIMEOUT+1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  md_state_t  r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [4:0] r_rd, w_rd_nxt;
  md_kind_t   r_kind, w_kind_nxt;
  logic       r_exc, w_exc_nxt;

  logic       w_is_md;
  md_kind_t   w_kind;
  logic       w_issue;

  alu_decode u_decode (
    .i_ir     (DXIR),
    .o_alu_op (aluOp),
    .o_sham   (sham),
    .o_sx_mux (SXmux),
    .o_is_md  (w_is_md),
    .o_kind   (w_kind)
  );

  assign w_issue   = (r_state == ST_IDLE) && dx_valid && w_is_md && !flush;
  assign dbg_state = r_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_rd    <= 5'd0;
      r_kind  <= KIND_MUL;
      r_exc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd    <= w_rd_nxt;
      r_kind  <= w_kind_nxt;
      r_exc   <= w_exc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_nxt    = r_rd;
    w_kind_nxt  = r_kind;
    w_exc_nxt   = r_exc;
    ctrlMult    = 1'b0;
    ctrlDiv     = 1'b0;
    stall       = 1'b0;
    md_wb_valid = 1'b0;
    md_wb_rd    = 5'd0;
    md_wb_isExc = 1'b0;
    md_wb_code  = 32'd0;

    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          ctrlMult    = (w_kind == KIND_MUL);
          ctrlDiv     = (w_kind == KIND_DIV);
          stall       = 1'b1;
          w_rd_nxt    = DXIR[RD_LSB +: 5];
          w_kind_nxt  = w_kind;
          w_cnt_nxt   = 8'd0;
          w_exc_nxt   = 1'b0;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A flush abandons the operation; releasing stall the same cycle lets
        // the redirected fetch proceed immediately.
        stall = !flush;
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (md_resultRdy) begin
          w_exc_nxt   = md_exception;
          w_state_nxt = ST_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_exc_nxt   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_DONE: begin
        md_wb_valid = 1'b1;
        if (r_exc) begin
          md_wb_rd    = 5'(STATUS_REG);
          md_wb_isExc = 1'b1;
          md_wb_code  = (r_kind == KIND_DIV) ? 32'(DIV_EXC) : 32'(MULT_EXC);
        end else begin
          md_wb_rd = r_rd;
        end
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_md_ctrl.sv
// Directed bench for alu_md_ctrl with TIMEOUT=8. Inputs change 1 time unit
// after the rising edge and outputs are checked 1 unit later.
module tb_alu_md_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] DXIR;
  logic        dx_valid;
  logic        flush;
  logic        md_resultRdy;
  logic        md_exception;
  logic [4:0]  aluOp;
  logic [4:0]  sham;
  logic        SXmux;
  logic        ctrlMult;
  logic        ctrlDiv;
  logic        stall;
  logic        md_wb_valid;
  logic [4:0]  md_wb_rd;
  logic        md_wb_isExc;
  logic [31:0] md_wb_code;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  alu_md_ctrl #(
    .TIMEOUT    (8),
    .MULT_EXC   (4),
    .DIV_EXC    (5),
    .STATUS_REG (30)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .DXIR         (DXIR),
    .dx_valid     (dx_valid),
    .flush        (flush),
    .md_resultRdy (md_resultRdy),
    .md_exception (md_exception),
    .aluOp        (aluOp),
    .sham         (sham),
    .SXmux        (SXmux),
    .ctrlMult     (ctrlMult),
    .ctrlDiv      (ctrlDiv),
    .stall        (stall),
    .md_wb_valid  (md_wb_valid),
    .md_wb_rd     (md_wb_rd),
    .md_wb_isExc  (md_wb_isExc),
    .md_wb_code   (md_wb_code),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [4:0] rd,
                                     input logic [4:0] shamt, input logic [4:0] func);
    return {opc, rd, 10'd0, shamt, func, 2'b00};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dec(input string tag, input logic [4:0] op, input logic [4:0] sh,
                         input logic sx);
    chk({tag, ".aluOp"}, 32'(aluOp), 32'(op));
    chk({tag, ".sham"},  32'(sham),  32'(sh));
    chk({tag, ".SXmux"}, 32'(SXmux), 32'(sx));
  endtask

  task automatic chk_ctl(input string tag, input logic cm, input logic cd, input logic st);
    chk({tag, ".ctrlMult"}, 32'(ctrlMult), 32'(cm));
    chk({tag, ".ctrlDiv"},  32'(ctrlDiv),  32'(cd));
    chk({tag, ".stall"},    32'(stall),    32'(st));
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic [4:0] rd,
                        input logic exc, input logic [31:0] code);
    chk({tag, ".wb_valid"}, 32'(md_wb_valid), 32'(v));
    chk({tag, ".wb_rd"},    32'(md_wb_rd),    32'(rd));
    chk({tag, ".wb_isExc"}, 32'(md_wb_isExc), 32'(exc));
    chk({tag, ".wb_code"},  md_wb_code,       code);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset        = 1'b1;
    DXIR         = 32'd0;
    dx_valid     = 1'b0;
    flush        = 1'b0;
    md_resultRdy = 1'b0;
    md_exception = 1'b0;
    step();
    step();
    reset = 1'b0;
    settle();

    // Reset state
    chk("rst.state", 32'(dbg_state), 32'd0);
    chk_ctl("rst", 1'b0, 1'b0, 1'b0);
    chk_wb("rst", 1'b0, 5'd0, 1'b0, 32'd0);

    // ALU decode: add, shift with shamt, addi, branches
    DXIR = mk(5'd0, 5'd1, 5'd3, 5'd0); dx_valid = 1'b1; settle();
    chk_dec("add", 5'd0, 5'd3, 1'b0);
    chk("add.stall", 32'(stall), 32'd0);
    DXIR = mk(5'd0, 5'd1, 5'd5, 5'd4); settle();
    chk_dec("sll", 5'd4, 5'd5, 1'b0);
    DXIR = mk(5'd5, 5'd1, 5'd9, 5'd3); settle();
    chk_dec("addi", 5'd0, 5'd0, 1'b1);
    DXIR = mk(5'd2, 5'd1, 5'd0, 5'd0); settle();
    chk_dec("bne", 5'd1, 5'd0, 1'b0);
    DXIR = mk(5'd6, 5'd1, 5'd0, 5'd0); settle();
    chk_dec("blt", 5'd1, 5'd0, 1'b0);
    DXIR = mk(5'd22, 5'd0, 5'd0, 5'd0); settle();
    chk_dec("bex", 5'd1, 5'd0, 1'b0);

    // Flush in IDLE blocks the issue
    DXIR = mk(5'd0, 5'd7, 5'd0, 5'd6); flush = 1'b1; settle();
    chk_ctl("idle_flush", 1'b0, 1'b0, 1'b0);
    step();
    chk("idle_flush.state", 32'(dbg_state), 32'd0);
    flush = 1'b0; settle();

    // mult rd=7, result 4 cycles after issue, no exception
    chk_ctl("mul.T", 1'b1, 1'b0, 1'b1);
    chk_dec("mul.T", 5'd0, 5'd0, 1'b0);
    step();
    chk_ctl("mul.T1", 1'b0, 1'b0, 1'b1);
    chk("mul.T1.state", 32'(dbg_state), 32'd1);
    step();
    chk_ctl("mul.T2", 1'b0, 1'b0, 1'b1);
    step();
    chk_ctl("mul.T3", 1'b0, 1'b0, 1'b1);
    step();
    md_resultRdy = 1'b1; settle();
    chk_ctl("mul.T4", 1'b0, 1'b0, 1'b1);
    chk("mul.T4.wb_valid", 32'(md_wb_valid), 32'd0);
    step();
    md_resultRdy = 1'b0; settle();
    chk_ctl("mul.T5", 1'b0, 1'b0, 1'b0);
    chk_wb("mul.T5", 1'b1, 5'd7, 1'b0, 32'd0);
    dx_valid = 1'b0;
    step();
    chk("mul.T6.state", 32'(dbg_state), 32'd0);
    chk("mul.T6.wb_valid", 32'(md_wb_valid), 32'd0);

    // div rd=3, result at T+1 with exception
    DXIR = mk(5'd0, 5'd3, 5'd0, 5'd7); dx_valid = 1'b1; settle();
    chk_ctl("div.T", 1'b0, 1'b1, 1'b1);
    step();
    md_resultRdy = 1'b1; md_exception = 1'b1; settle();
    chk_ctl("div.T1", 1'b0, 1'b0, 1'b1);
    step();
    md_resultRdy = 1'b0; md_exception = 1'b0; settle();
    chk_wb("div.T2", 1'b1, 5'd30, 1'b1, 32'd5);
    chk("div.T2.stall", 32'(stall), 32'd0);
    dx_valid = 1'b0;
    step();
    chk("div.T3.wb_valid", 32'(md_wb_valid), 32'd0);

    // mult rd=9 with no result: timeout write-back at T+9
    DXIR = mk(5'd0, 5'd9, 5'd0, 5'd6); dx_valid = 1'b1; settle();
    chk_ctl("to.T", 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("to.T%0d.stall", i), 32'(stall), 32'd1);
      chk($sformatf("to.T%0d.wb_valid", i), 32'(md_wb_valid), 32'd0);
    end
    step();
    chk_wb("to.T9", 1'b1, 5'd30, 1'b1, 32'd4);
    chk("to.T9.stall", 32'(stall), 32'd0);
    dx_valid = 1'b0;
    step();
    chk("to.T10.state", 32'(dbg_state), 32'd0);

    // flush two cycles into BUSY, then a late result
    DXIR = mk(5'd0, 5'd4, 5'd0, 5'd6); dx_valid = 1'b1; settle();
    chk_ctl("fl.T", 1'b1, 1'b0, 1'b1);
    step();
    step();
    flush = 1'b1; settle();
    chk_ctl("fl.T2", 1'b0, 1'b0, 1'b0);
    step();
    flush = 1'b0; dx_valid = 1'b0; md_resultRdy = 1'b1; settle();
    chk("fl.T3.state", 32'(dbg_state), 32'd0);
    chk_wb("fl.T3", 1'b0, 5'd0, 1'b0, 32'd0);
    chk("fl.T3.stall", 32'(stall), 32'd0);
    step();
    md_resultRdy = 1'b0; settle();
    chk("fl.T4.wb_valid", 32'(md_wb_valid), 32'd0);

    // Reset mid-BUSY
    DXIR = mk(5'd0, 5'd2, 5'd0, 5'd7); dx_valid = 1'b1; settle();
    chk_ctl("rb.T", 1'b0, 1'b1, 1'b1);
    step();
    step();
    reset = 1'b1; dx_valid = 1'b0; settle();
    step();
    reset = 1'b0; md_resultRdy = 1'b1; settle();
    chk("rb.state", 32'(dbg_state), 32'd0);
    chk_ctl("rb", 1'b0, 1'b0, 1'b0);
    chk_wb("rb", 1'b0, 5'd0, 1'b0, 32'd0);
    step();
    md_resultRdy = 1'b0; settle();
    chk("rb.late.wb_valid", 32'(md_wb_valid), 32'd0);

    // Back-to-back mult rd=5 then div rd=6
    DXIR = mk(5'd0, 5'd5, 5'd0, 5'd6); dx_valid = 1'b1; settle();
    chk_ctl("bb.T", 1'b1, 1'b0, 1'b1);
    step();
    md_resultRdy = 1'b1; settle();
    step();
    md_resultRdy = 1'b0;
    DXIR = mk(5'd0, 5'd6, 5'd0, 5'd7); settle();
    chk_wb("bb.R1", 1'b1, 5'd5, 1'b0, 32'd0);
    chk_ctl("bb.R1", 1'b0, 1'b0, 1'b0);
    step();
    chk_ctl("bb.R2", 1'b0, 1'b1, 1'b1);
    chk("bb.R2.wb_valid", 32'(md_wb_valid), 32'd0);
    step();
    md_resultRdy = 1'b1; settle();
    step();
    md_resultRdy = 1'b0; dx_valid = 1'b0; settle();
    chk_wb("bb.div", 1'b1, 5'd6, 1'b0, 32'd0);
    step();
    chk("bb.end.state", 32'(dbg_state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
